regfile_gen: RTL and testbench
==============================

# regfile_gen

Parametrised general-purpose register file for the group's processor datapath. It has two registered read ports and one write port, and a read and a write may occur in the same cycle. It supports a configurable register count and width and a virtual PC slot that returns the fetch stage's PC+ value. A hardware clear sequencer sweeps the array to its reset image after reset or on request.

## Interface
Parameters:
- REG_WIDTH, 16, data width of every register and port.
- NUM_REGS, 16, number of addressable slots including the PC slot; 2..2**ADDR_W.
- ADDR_W, 4, address width.
- SP_IDX, 13, index of the stack pointer.
- SP_RESET, 16'h00a0, value loaded into SP_IDX by the clear sequence.
- PC_IDX, 15, virtual PC slot; must be < NUM_REGS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_1_init  in  1  single-cycle request to re-run the clear sequence; honoured only in RUN.
- i_1_rd_en  in  1  read strobe for both read ports.
- i_A_rd1_addr  in  ADDR_W  read port 1 address.
- i_A_rd2_addr  in  ADDR_W  read port 2 address.
- i_1_reg_wr_en  in  1  write strobe.
- i_A_wr_addr  in  ADDR_W  write address.
- i_R_wr_data  in  REG_WIDTH  write data.
- i_R_pcplus  in  REG_WIDTH  PC+ value returned for PC_IDX reads.
- o_1_ready  out  1  high in RUN; low during reset and clearing.
- or_R_rd1_data  out  REG_WIDTH  registered read data, port 1.
- or_R_rd2_data  out  REG_WIDTH  registered read data, port 2.
- or_1_rd_valid  out  1  high for one cycle when the read data outputs are updated.
- or_1_pc_wr  out  1  one-cycle pulse when a write targets PC_IDX.
- or_R_pc_wr_data  out  REG_WIDTH  data captured with or_1_pc_wr.

## Operation
- FSM states are CLEAR and RUN. rst low forces CLEAR with sweep index 0.
- CLEAR:
  - Each cycle writes slot[idx] with SP_RESET if idx==SP_IDX, otherwise 0. The index then increments.
  - PC_IDX is skipped and not stored.
  - After idx==NUM_REGS-1 is written, the FSM goes to RUN.
- In CLEAR, i_1_rd_en, i_1_reg_wr_en and i_1_init are ignored. or_1_rd_valid and or_1_pc_wr stay 0, and the read outputs hold.
- RUN, i_1_init=1: go to CLEAR with idx 0 on the next edge. A write or read presented in the same cycle is dropped.
- RUN, write with i_1_reg_wr_en=1:
  - A write to slot wr_addr (≠PC_IDX, <NUM_REGS) updates that slot at the edge.
  - A write to PC_IDX is not stored. It pulses or_1_pc_wr and loads or_R_pc_wr_data.
  - A write with wr_addr >= NUM_REGS is ignored.
- RUN, read with i_1_rd_en=1:
  - Each port loads the addressed slot.
  - PC_IDX returns i_R_pcplus as sampled in the request cycle.
  - An address >= NUM_REGS returns 0.
  - or_1_rd_valid pulses.
- Simultaneous read and write to the same address follows REGFILE_BYPASS_EN (see Configuration). Reads of PC_IDX are never bypassed.

## Timing
- Reset values (rst low, asynchronous):
  - o_1_ready, or_1_rd_valid and or_1_pc_wr are 0.
  - or_R_rd1_data, or_R_rd2_data and or_R_pc_wr_data are 0.
  - The array is undefined until CLEAR completes.
- Clear latency: NUM_REGS rising edges after rst deasserts. o_1_ready rises after the NUM_REGS-th edge. With the defaults it rises after edge 16.
- Requesting re-clear: i_1_init asserts in cycle N. o_1_ready drops after edge N and rises again NUM_REGS edges later.
- Read latency is 1 cycle. Data and or_1_rd_valid appear after the edge that samples i_1_rd_en.
- A write is visible to a read issued in the following cycle, independent of the macro.
- rst asserted mid-sweep or mid-operation aborts immediately. The sequence restarts at idx 0 after release.

## Configuration
- REGFILE_BYPASS_EN:
  - Defined: write-first. A same-cycle read of wr_addr returns i_R_wr_data on the affected port(s).
  - Undefined: read-first. The read returns the pre-write contents.

## Test plan
- Release rst at edge 0 (defaults) -> o_1_ready=0 through edge 15, =1 after edge 16. Reading r13 returns 16'h00a0 and r2 returns 0; or_1_rd_valid=1 for exactly one cycle.
- Write r3=16'h1234, then read rd1=3, rd2=15 with i_R_pcplus=16'h0042 -> after one cycle, rd1=16'h1234, rd2=16'h0042 and or_1_rd_valid=1.
- Same-cycle write r5=16'hbeef and read rd1=5, with r5 previously 16'h0001 -> rd1=16'hbeef if REGFILE_BYPASS_EN is defined, else 16'h0001; the next read returns 16'hbeef either way.
- Write addr 15 with data 16'h0200 -> or_1_pc_wr=1 for one cycle and or_R_pc_wr_data=16'h0200; a subsequent read of 15 returns i_R_pcplus.
- Write r7=16'h00ff, pulse i_1_init, and assert rst low at sweep idx 4 -> outputs zero immediately, o_1_ready=0, and the full 16-cycle sweep reruns; r7 then reads 0.
- NUM_REGS=8, ADDR_W=4, PC_IDX=7: write addr 9 and read addr 9 -> no slot changes and the read returns 0.

Source files
------------

// File: rtl/regfile_gen.sv
`default_nettype none
// ============================================================================
// Module   : regfile_gen
// Brief    : 2R/1W registered-read register file with a virtual PC slot and a
//            hardware clear sweep; REGFILE_BYPASS_EN selects write-first reads.
// Revision : 1.0  initial release
// ============================================================================
module regfile_gen #(
  parameter int                   REG_WIDTH = 16,
  parameter int                   NUM_REGS  = 16,
  parameter int                   ADDR_W    = 4,
  parameter int                   SP_IDX    = 13,
  parameter logic [REG_WIDTH-1:0] SP_RESET  = 16'h00a0,
  parameter int                   PC_IDX    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_1_init,
  input  logic                 i_1_rd_en,
  input  logic [ADDR_W-1:0]    i_A_rd1_addr,
  input  logic [ADDR_W-1:0]    i_A_rd2_addr,
  input  logic                 i_1_reg_wr_en,
  input  logic [ADDR_W-1:0]    i_A_wr_addr,
  input  logic [REG_WIDTH-1:0] i_R_wr_data,
  input  logic [REG_WIDTH-1:0] i_R_pcplus,
  output logic                 o_1_ready,
  output logic [REG_WIDTH-1:0] or_R_rd1_data,
  output logic [REG_WIDTH-1:0] or_R_rd2_data,
  output logic                 or_1_rd_valid,
  output logic                 or_1_pc_wr,
  output logic [REG_WIDTH-1:0] or_R_pc_wr_data
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   c_num_regs = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_pc_idx   = ADDR_W'(PC_IDX);
  localparam logic [ADDR_W-1:0] c_sp_idx   = ADDR_W'(SP_IDX);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     r_idx;
  logic [ADDR_W-1:0]     w_idx_nxt;
  logic [REG_WIDTH-1:0]  r_regs [NUM_REGS];

  logic                  w_run_ok;
  logic                  w_rd_go;
  logic                  w_wr_go;
  logic                  w_pc_go;
  logic                  w_wr_in_range;
  logic                  w_arr_we;
  logic [ADDR_W-1:0]     w_arr_addr;
  logic [REG_WIDTH-1:0]  w_arr_data;
  logic [REG_WIDTH-1:0]  w_rd1_data;
  logic [REG_WIDTH-1:0]  w_rd2_data;

  logic [REG_WIDTH-1:0]  r_rd1_data;
  logic [REG_WIDTH-1:0]  r_rd2_data;
  logic                  r_rd_valid;
  logic                  r_pc_wr;
  logic [REG_WIDTH-1:0]  r_pc_wr_data;

  // An init request in RUN swallows any read or write in the same cycle.
  assign w_run_ok      = (r_state == ST_RUN) && !i_1_init;
  assign w_wr_in_range = ({1'b0, i_A_wr_addr} < c_num_regs);
  assign w_rd_go       = w_run_ok && i_1_rd_en;
  assign w_wr_go       = w_run_ok && i_1_reg_wr_en && w_wr_in_range &&
                         (i_A_wr_addr != c_pc_idx);
  assign w_pc_go       = w_run_ok && i_1_reg_wr_en && (i_A_wr_addr == c_pc_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_CLEAR: begin
        if (r_idx == c_last_idx) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_1_init) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Single array write port shared by the clear sweep and normal writes.
  always_comb begin
    w_arr_we   = w_wr_go;
    w_arr_addr = i_A_wr_addr;
    w_arr_data = i_R_wr_data;
    if (r_state == ST_CLEAR) begin
      w_arr_we   = (r_idx != c_pc_idx);
      w_arr_addr = r_idx;
      w_arr_data = (r_idx == c_sp_idx) ? SP_RESET : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_arr_we && (w_arr_addr == ADDR_W'(i))) begin
        r_regs[i] <= w_arr_data;
      end
    end
  end

  always_comb begin
    w_rd1_data = '0;
    w_rd2_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_A_rd1_addr == ADDR_W'(i)) w_rd1_data = r_regs[i];
      if (i_A_rd2_addr == ADDR_W'(i)) w_rd2_data = r_regs[i];
    end
`ifdef REGFILE_BYPASS_EN
    // w_wr_go already excludes the PC slot, so PC reads are never bypassed.
    if (w_wr_go && (i_A_rd1_addr == i_A_wr_addr)) w_rd1_data = i_R_wr_data;
    if (w_wr_go && (i_A_rd2_addr == i_A_wr_addr)) w_rd2_data = i_R_wr_data;
`endif
    if (i_A_rd1_addr == c_pc_idx) w_rd1_data = i_R_pcplus;
    if (i_A_rd2_addr == c_pc_idx) w_rd2_data = i_R_pcplus;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd1_data   <= '0;
      r_rd2_data   <= '0;
      r_rd_valid   <= 1'b0;
      r_pc_wr      <= 1'b0;
      r_pc_wr_data <= '0;
    end else begin
      r_rd_valid <= w_rd_go;
      r_pc_wr    <= w_pc_go;
      if (w_rd_go) begin
        r_rd1_data <= w_rd1_data;
        r_rd2_data <= w_rd2_data;
      end
      if (w_pc_go) begin
        r_pc_wr_data <= i_R_wr_data;
      end
    end
  end

  assign o_1_ready       = (r_state == ST_RUN);
  assign or_R_rd1_data   = r_rd1_data;
  assign or_R_rd2_data   = r_rd2_data;
  assign or_1_rd_valid   = r_rd_valid;
  assign or_1_pc_wr      = r_pc_wr;
  assign or_R_pc_wr_data = r_pc_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_gen
// Brief    : Directed self-checking bench for regfile_gen (default and 8-slot).
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_gen;

  logic        clk;
  logic        rst;
  logic        init;
  logic        rd_en;
  logic [3:0]  rd1_addr;
  logic [3:0]  rd2_addr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pcplus;
  logic        ready;
  logic [15:0] rd1_data;
  logic [15:0] rd2_data;
  logic        rd_valid;
  logic        pc_wr;
  logic [15:0] pc_wr_data;

  logic        rd_en8;
  logic [3:0]  rd1_addr8;
  logic [3:0]  rd2_addr8;
  logic        wr_en8;
  logic [3:0]  wr_addr8;
  logic [15:0] wr_data8;
  logic        ready8;
  logic [15:0] rd1_data8;
  logic [15:0] rd2_data8;
  logic        rd_valid8;
  logic        pc_wr8;
  logic [15:0] pc_wr_data8;

  int checks = 0;
  int errors = 0;

  regfile_gen dut (
    .clk            (clk),
    .rst            (rst),
    .i_1_init       (init),
    .i_1_rd_en      (rd_en),
    .i_A_rd1_addr   (rd1_addr),
    .i_A_rd2_addr   (rd2_addr),
    .i_1_reg_wr_en  (wr_en),
    .i_A_wr_addr    (wr_addr),
    .i_R_wr_data    (wr_data),
    .i_R_pcplus     (pcplus),
    .o_1_ready      (ready),
    .or_R_rd1_data  (rd1_data),
    .or_R_rd2_data  (rd2_data),
    .or_1_rd_valid  (rd_valid),
    .or_1_pc_wr     (pc_wr),
    .or_R_pc_wr_data(pc_wr_data)
  );

  regfile_gen #(.NUM_REGS(8), .ADDR_W(4), .PC_IDX(7)) dut8 (
    .clk            (clk),
    .rst            (rst),
    .i_1_init       (1'b0),
    .i_1_rd_en      (rd_en8),
    .i_A_rd1_addr   (rd1_addr8),
    .i_A_rd2_addr   (rd2_addr8),
    .i_1_reg_wr_en  (wr_en8),
    .i_A_wr_addr    (wr_addr8),
    .i_R_wr_data    (wr_data8),
    .i_R_pcplus     (pcplus),
    .o_1_ready      (ready8),
    .or_R_rd1_data  (rd1_data8),
    .or_R_rd2_data  (rd2_data8),
    .or_1_rd_valid  (rd_valid8),
    .or_1_pc_wr     (pc_wr8),
    .or_R_pc_wr_data(pc_wr_data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle past it before checking/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_byp;
    rst = 1'b0; init = 1'b0; rd_en = 1'b0; rd1_addr = '0; rd2_addr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; pcplus = '0;
    rd_en8 = 1'b0; rd1_addr8 = '0; rd2_addr8 = '0;
    wr_en8 = 1'b0; wr_addr8 = '0; wr_data8 = '0;

    #1;
    check("rst_ready",  32'(ready),      32'h0);
    check("rst_rd1",    32'(rd1_data),   32'h0);
    check("rst_rd2",    32'(rd2_data),   32'h0);
    check("rst_valid",  32'(rd_valid),   32'h0);
    check("rst_pcwr",   32'(pc_wr),      32'h0);
    check("rst_pcdata", 32'(pc_wr_data), 32'h0);
    tick();
    tick();
    rst = 1'b1;

    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("clr_ready_e%0d", k), 32'(ready), (k == 16) ? 32'h1 : 32'h0);
    end

    rd_en = 1'b1; rd1_addr = 4'd13; rd2_addr = 4'd2;
    tick();
    rd_en = 1'b0;
    check("sp_rd1",    32'(rd1_data), 32'h00a0);
    check("r2_rd2",    32'(rd2_data), 32'h0000);
    check("sp_valid",  32'(rd_valid), 32'h1);
    tick();
    check("valid_drop", 32'(rd_valid), 32'h0);

    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd1_addr = 4'd3; rd2_addr = 4'd15; pcplus = 16'h0042;
    tick();
    rd_en = 1'b0;
    check("r3_rd1",   32'(rd1_data), 32'h1234);
    check("pc_rd2",   32'(rd2_data), 32'h0042);
    check("r3_valid", 32'(rd_valid), 32'h1);

    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0001;
    tick();
    wr_data = 16'hbeef; rd_en = 1'b1; rd1_addr = 4'd5; rd2_addr = 4'd3;
    tick();
    wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 16'hbeef;
`else
    exp_byp = 16'h0001;
`endif
    check("same_cyc_rd1", 32'(rd1_data), 32'(exp_byp));
    check("same_cyc_rd2", 32'(rd2_data), 32'h1234);
    tick();
    rd_en = 1'b0;
    check("after_wr_rd1", 32'(rd1_data), 32'hbeef);

    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h0200;
    tick();
    wr_en = 1'b0;
    check("pcwr_pulse", 32'(pc_wr),      32'h1);
    check("pcwr_data",  32'(pc_wr_data), 32'h0200);
    rd_en = 1'b1; rd1_addr = 4'd15; rd2_addr = 4'd5; pcplus = 16'h5555;
    tick();
    rd_en = 1'b0;
    check("pcwr_drop",  32'(pc_wr),      32'h0);
    check("pcwr_hold",  32'(pc_wr_data), 32'h0200);
    check("pc_rd1",     32'(rd1_data),   32'h5555);
    check("r5_rd2",     32'(rd2_data),   32'hbeef);

    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00ff;
    tick();
    wr_en = 1'b0; init = 1'b1;
    tick();
    init = 1'b0;
    check("init_ready", 32'(ready), 32'h0);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b0;
    #1;
    check("abort_ready",  32'(ready),      32'h0);
    check("abort_rd1",    32'(rd1_data),   32'h0);
    check("abort_rd2",    32'(rd2_data),   32'h0);
    check("abort_pcdata", 32'(pc_wr_data), 32'h0);
    tick();
    rst = 1'b1;

    // Requests during the sweep must be ignored.
    rd_en = 1'b1; rd1_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'hffff;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("reclr_ready_e%0d", k), 32'(ready), (k == 16) ? 32'h1 : 32'h0);
      check($sformatf("reclr_valid_e%0d", k), 32'(rd_valid), 32'h0);
    end
    rd_en = 1'b1; rd1_addr = 4'd7; rd2_addr = 4'd13; wr_en = 1'b0;
    tick();
    rd_en = 1'b0;
    check("r7_cleared", 32'(rd1_data), 32'h0);
    check("sp_reclr",   32'(rd2_data), 32'h00a0);

    check("n8_ready", 32'(ready8), 32'h1);
    wr_en8 = 1'b1; wr_addr8 = 4'd9; wr_data8 = 16'habcd;
    rd_en8 = 1'b1; rd1_addr8 = 4'd9; rd2_addr8 = 4'd1;
    tick();
    wr_en8 = 1'b0;
    check("n8_oor_same", 32'(rd1_data8), 32'h0);
    rd1_addr8 = 4'd9; rd2_addr8 = 4'd1;
    tick();
    check("n8_oor_rd1", 32'(rd1_data8), 32'h0);
    check("n8_r1_rd2",  32'(rd2_data8), 32'h0);
    check("n8_valid",   32'(rd_valid8), 32'h1);
    rd1_addr8 = 4'd7; pcplus = 16'h0777;
    tick();
    rd_en8 = 1'b0;
    check("n8_pc_rd1",  32'(rd1_data8), 32'h0777);
    check("n8_pcwr",    32'(pc_wr8),    32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
